// File: rtl/dac_sample_sched.sv
// Sample-rate scheduler feeding a 16-bit serial DAC frame.
// One holding register, bypass on tick, resend-last on underrun.
module dac_sample_sched #(
  parameter logic [15:0] DIV_INIT  = 16'd1000,
  parameter int unsigned SCLK_HALF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rate_req,
  input  logic [15:0] rate_val,
  output logic        rate_ack,
  input  logic [11:0] smp_data,
  input  logic        smp_valid,
  output logic        smp_ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        busy,
  output logic        err_underrun
);

  localparam int unsigned MIN_I = 2*SCLK_HALF*16 + 2*SCLK_HALF + 2;
  localparam logic [15:0] MIN_DIV = 16'(MIN_I);
  localparam logic [15:0] DIV_RST =
    (DIV_INIT > MIN_DIV) ? DIV_INIT : MIN_DIV;
  localparam int PW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SCLK_HALF - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} st_t;

  st_t         st_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic        full_q, full_d;
  logic [11:0] hold_q, hold_d;
  logic [11:0] last_q, last_d;
  logic        err_q, err_d;
  logic [15:0] sh_q;
  logic [PW-1:0] ph_q;
  logic [3:0]  bit_q;
  logic        cs_n_q, sclk_q, din_q;
  logic        tick, hs, ph_end;
  logic [11:0] frame_smp;
  logic [15:0] frame_word;

  assign tick      = (cnt_q == div_q - 16'd1);
  assign smp_ready = !full_q && !reset;
  assign hs        = smp_valid && smp_ready;
  assign rate_ack  = tick && rate_req && !reset;
  assign ph_end    = (ph_q == PH_LAST);

  always_comb begin
    cnt_d     = tick ? 16'd0 : cnt_q + 16'd1;
    div_d     = div_q;
    full_d    = full_q;
    hold_d    = hold_q;
    last_d    = last_q;
    err_d     = err_q;
    frame_smp = last_q;
    if (rate_ack)
      div_d = (rate_val > MIN_DIV) ? rate_val : MIN_DIV;
    if (tick) begin
      if (full_q) begin
        frame_smp = hold_q;
        full_d    = 1'b0;
      end else if (hs) begin
        frame_smp = smp_data;
      end else begin
        err_d = 1'b1;
      end
      last_d = frame_smp;
    end else if (hs) begin
      full_d = 1'b1;
      hold_d = smp_data;
    end
    frame_word = {4'b0000, frame_smp};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 16'd0;
      div_q  <= DIV_RST;
      full_q <= 1'b0;
      hold_q <= 12'd0;
      last_q <= 12'd0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      full_q <= full_d;
      hold_q <= hold_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  // Ticks only land in IDLE since the period always covers a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      din_q  <= 1'b0;
      sh_q   <= 16'd0;
      ph_q   <= '0;
      bit_q  <= 4'd0;
    end else begin
      unique case (st_q)
        IDLE: if (tick) begin
          st_q   <= SETUP;
          cs_n_q <= 1'b0;
          sh_q   <= frame_word;
          din_q  <= frame_word[15];
          ph_q   <= '0;
        end
        SETUP: if (ph_end) begin
          st_q  <= SHIFT;
          ph_q  <= '0;
          bit_q <= 4'd15;
        end else begin
          ph_q <= ph_q + 1'b1;
        end
        SHIFT: if (!ph_end) begin
          ph_q <= ph_q + 1'b1;
        end else begin
          ph_q <= '0;
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else begin
            sclk_q <= 1'b0;
            if (bit_q == 4'd0) begin
              st_q <= HOLD;
            end else begin
              bit_q <= bit_q - 4'd1;
              sh_q  <= {sh_q[14:0], 1'b0};
              din_q <= sh_q[14];
            end
          end
        end
        HOLD: if (ph_end) begin
          st_q   <= IDLE;
          cs_n_q <= 1'b1;
          din_q  <= 1'b0;
          ph_q   <= '0;
        end else begin
          ph_q <= ph_q + 1'b1;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_din      = din_q;
  assign busy         = !cs_n_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Bench for dac_sample_sched: random traffic vs a period/queue model,
// serial frames decoded from the pins and matched to expected words.
module tb_dac_sample_sched;

  logic        clk = 1'b0;
  logic        reset, rate_req, rate_ack;
  logic [15:0] rate_val;
  logic [11:0] smp_data;
  logic        smp_valid, smp_ready;
  logic        dac_cs_n, dac_sclk, dac_din, busy, err_underrun;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dac_sample_sched dut (
    .clk(clk),
    .reset(reset),
    .rate_req(rate_req),
    .rate_val(rate_val),
    .rate_ack(rate_ack),
    .smp_data(smp_data),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .dac_cs_n(dac_cs_n),
    .dac_sclk(dac_sclk),
    .dac_din(dac_din),
    .busy(busy),
    .err_underrun(err_underrun)
  );

  // reference model: period, holding slot, last sample, expected frames
  int          m_cnt = 0;
  int          m_div = 1000;
  bit          m_full = 0;
  logic [11:0] m_hold = '0;
  logic [11:0] m_last = '0;
  bit          m_err = 0;
  logic [15:0] fq[$];
  int          t_tick = -100;

  bit          rr_on = 0;
  logic [15:0] rr_val = '0;
  bit          prev_rst = 1;
  int          rel = 0;
  bit          fpend = 0;

  // pin-level frame decoder
  bit          in_frame = 0;
  int          t_fall = 0;
  int          nbits = 0;
  logic [15:0] word = '0;
  logic        prev_sclk = 1'b0;
  logic        hi_din = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [15:0] w16;
    if (in_frame) begin
      if (dac_cs_n) begin
        chk("frame_len", cyc - t_fall, 68);
        chk("frame_bits", nbits, 16);
        if (fq.size() == 0) begin
          chk("frame_expected", 0, 1);
        end else begin
          w16 = fq.pop_front();
          chk("frame_word", {16'h0, word}, {16'h0, w16});
        end
        in_frame = 0;
      end else if (dac_sclk && !prev_sclk) begin
        word   = {word[14:0], dac_din};
        nbits++;
        hi_din = dac_din;
      end else if (dac_sclk) begin
        chk("din_stable", dac_din, hi_din);
      end
    end else if (!dac_cs_n) begin
      in_frame = 1;
      t_fall   = cyc;
      nbits    = 0;
      word     = '0;
      chk("cs_latency", cyc - t_tick, 1);
      chk("setup_sclk", dac_sclk, 0);
      if (fpend) begin
        chk("tick_after_rst", cyc - rel, 1000);
        fpend = 0;
      end
    end else begin
      chk("idle_out", {dac_sclk, dac_din}, 2'b00);
    end
    prev_sclk = dac_sclk;
  endtask

  task automatic step(input bit rst, input bit v, input logic [11:0] d);
    bit          tk;
    logic [11:0] w;
    monitor();
    chk("err", err_underrun, m_err);
    chk("busy", busy, !dac_cs_n);
    if (prev_rst) chk("rst_csn", dac_cs_n, 1);
    if (!rst && prev_rst) begin
      rel   = cyc;
      fpend = 1;
    end
    reset     = rst;
    smp_valid = v;
    smp_data  = d;
    rate_req  = rr_on;
    rate_val  = rr_val;
    #1;
    tk = !rst && (m_cnt == m_div - 1);
    chk("ready", smp_ready, !rst && !m_full);
    chk("ack", rate_ack, tk && rr_on);
    if (rst) begin
      m_cnt = 0; m_div = 1000; m_full = 0;
      m_hold = '0; m_last = '0; m_err = 0;
      fq.delete();
      in_frame = 0;
      fpend = 0;
    end else if (tk) begin
      if (rr_on) begin
        m_div = (rr_val < 16'd70) ? 70 : int'(rr_val);
        rr_on = 0;
      end
      m_cnt = 0;
      if (m_full) begin
        w = m_hold;
        m_full = 0;
      end else if (v) begin
        w = d;
      end else begin
        w = m_last;
        m_err = 1;
      end
      m_last = w;
      fq.push_back({4'h0, w});
      t_tick = cyc;
    end else begin
      m_cnt++;
      if (v && !m_full) begin
        m_full = 1;
        m_hold = d;
      end
    end
    prev_rst = rst;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rstep(input int pv);
    bit v;
    if (m_cnt == m_div - 1 && !m_full) v = bit'($urandom_range(0, 1));
    else v = ($urandom_range(0, 99) < pv);
    if (!rr_on && $urandom_range(0, 299) == 0) begin
      rr_on = 1;
      case ($urandom_range(0, 3))
        0: rr_val = 16'd0;
        1: rr_val = 16'($urandom_range(1, 69));
        2: rr_val = 16'($urandom_range(70, 71));
        default: rr_val = 16'($urandom_range(72, 400));
      endcase
    end
    step(0, v, 12'($urandom));
  endtask

  initial begin
    int n;
    reset = 1'b1; rate_req = 1'b1; rate_val = 16'd0;
    smp_data = '0; smp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rr_on = 1; rr_val = 16'd300;
    repeat (3) step(1, 0, '0);
    rr_on = 0;
    // first frame carries 0xA5C at default period
    step(0, 1, 12'hA5C);
    repeat (1100) step(0, 0, '0);
    // 0x123 frame, then a rate change and underrun resends
    step(0, 1, 12'h123);
    repeat (50) step(0, 0, '0);
    rr_on = 1; rr_val = 16'd200;
    repeat (1500) step(0, 0, '0);
    rr_on = 1; rr_val = 16'd5;
    repeat (400) rstep(30);
    repeat (1500) rstep(2);
    repeat (1500) rstep(40);
    // reset in the middle of bit 7
    n = 0;
    while (!(in_frame && nbits == 8 && !dac_cs_n) && n < 2000) begin
      rstep(20);
      n++;
    end
    if (n >= 2000) chk("reach_bit7", 0, 1);
    step(1, 0, '0);
    chk("abort_csn", dac_cs_n, 1);
    chk("abort_sclk", dac_sclk, 0);
    // bypass on the first tick with an empty register
    n = 0;
    while (m_cnt != m_div - 1 && n < 1100) begin
      step(0, 0, '0);
      n++;
    end
    if (n >= 1100) chk("reach_tick", 0, 1);
    step(0, 1, 12'h3C7);
    repeat (100) step(0, 0, '0);
    chk("bypass_no_err", err_underrun, 0);
    repeat (1500) rstep(10);
    // drain any frame still in flight
    rr_on = 0;
    n = 0;
    while ((in_frame || fq.size() != 0 || !dac_cs_n) && n < 500) begin
      step(0, 0, '0);
      n++;
    end
    if (n >= 500) chk("drain", 0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dac_sample_sched.md
DAC_SAMPLE_SCHED -- requirements
Module: dac_sample_sched

Interface
REQ-001 The module SHALL have parameter DIV_INIT, default 16'd1000, meaning the sample-period divider value loaded at reset.
REQ-002 The module SHALL have parameter SCLK_HALF, default 2, meaning system clocks per serial-clock half-period (≥1).
REQ-003 The module SHALL define MIN_DIV = 2*SCLK_HALF*16 + 2*SCLK_HALF + 2 (70 at defaults) as the smallest legal sample period.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rate_req  input  1  request to change the sample period; held until rate_ack.
REQ-007 rate_val  input  16  requested period in clk cycles; sampled on the cycle rate_ack is issued.
REQ-008 rate_ack  output  1  one-cycle pulse; new period accepted.
REQ-009 smp_data  input  12  DAC sample code.
REQ-010 smp_valid  input  1  smp_data valid.
REQ-011 smp_ready  output  1  holding register empty; transfer on smp_valid && smp_ready.
REQ-012 dac_cs_n  output  1  DAC chip select, active low.
REQ-013 dac_sclk  output  1  DAC serial clock, idle low.
REQ-014 dac_din  output  1  DAC serial data, MSB first.
REQ-015 busy  output  1  high while a frame is in progress (dac_cs_n low).
REQ-016 err_underrun  output  1  sticky; a sample tick found no new sample.

Function
REQ-017 A 16-bit period counter SHALL count 0..div_rate-1 and wrap; the cycle with count == div_rate-1 is the sample tick.
REQ-018 rate_req SHALL be honoured only on a tick cycle: that cycle rate_ack = 1, div_rate <= max(rate_val, MIN_DIV) (0 included), counter restarts at 0, new period effective from the next count.
REQ-019 rate_req without a tick SHALL leave div_rate unchanged and rate_ack = 0.
REQ-020 smp_ready SHALL be 1 whenever the holding register is empty and reset is low; a handshake fills it, and ready falls the following cycle.
REQ-021 On a tick with the holding register full, its content SHALL be loaded into the frame shifter and the register emptied (smp_ready = 1 next cycle).
REQ-022 On a tick with the register empty but smp_valid && smp_ready in the same cycle, smp_data SHALL be sent directly (bypass); no underrun.
REQ-023 On a tick with no sample available, the last transmitted sample SHALL be resent and err_underrun set to 1 until reset.
REQ-024 Frame word SHALL be {4'b0000, sample[11:0]}, 16 bits, MSB first.
REQ-025 Frame FSM states: IDLE, SETUP, SHIFT, HOLD; IDLE->SETUP on tick; SETUP->SHIFT after SCLK_HALF cycles; SHIFT->HOLD after 16 sclk periods; HOLD->IDLE after SCLK_HALF cycles.
REQ-026 dac_cs_n SHALL go low the cycle after the tick (latency 1) and return high on HOLD->IDLE; frame length 2*SCLK_HALF + 32*SCLK_HALF cycles (68 at defaults).
REQ-027 In SHIFT each bit: dac_sclk low SCLK_HALF cycles then high SCLK_HALF cycles; dac_din changes only when dac_sclk goes low (or on SETUP entry for bit 15) and is stable while high.
REQ-028 dac_sclk SHALL be low in IDLE, SETUP and HOLD; dac_din SHALL be 0 in IDLE.
REQ-029 busy SHALL equal !dac_cs_n; all serial outputs SHALL be registered.
REQ-030 Because div_rate ≥ MIN_DIV, a tick SHALL never occur outside IDLE; no frame overlap logic is required.
REQ-031 A rate change SHALL not affect a frame in progress.

Reset
REQ-032 While reset = 1 at a clock edge: counter 0, div_rate = max(DIV_INIT, MIN_DIV), FSM IDLE, holding register empty, last sample 0, dac_cs_n = 1, dac_sclk = 0, dac_din = 0, busy = 0, rate_ack = 0, err_underrun = 0, smp_ready = 0.
REQ-033 Reset mid-frame SHALL abort immediately: dac_cs_n = 1 at that edge; no partial frame resumes; smp_ready = 1 the first cycle after release.

Verification
REQ-034 Sample 12'hA5C accepted before first tick, defaults -> at count 999 tick, cs_n low next cycle, 16 bits 0x0A5C on din sampled at sclk rising edges, cs_n high 68 cycles after falling.
REQ-035 rate_req with rate_val = 16'd200 asserted mid-period -> rate_ack only at next tick, following ticks every 200 cycles; rate_val = 5 -> period 70.
REQ-036 No sample supplied before a tick after one frame of 12'h123 -> 0x0123 resent, err_underrun = 1 and stays 1 through later normal frames.
REQ-037 smp_valid rises exactly on tick cycle with register empty -> bypass frame carries that sample, err_underrun stays 0, smp_ready stays 1.
REQ-038 reset pulsed at SHIFT bit 7 -> dac_cs_n = 1 and dac_sclk = 0 at that edge, next tick after DIV_INIT cycles, err_underrun = 0.
